// File: rtl/ctrl_decode_pipe_if.sv
// Fetch-side bus of the control decode pipe: instruction handshake, flush and
// the packed per-stage control words that feed the downstream stages.
interface ctrl_decode_pipe_if #(
    parameter int DEPTH = 3
);
    localparam int CW = 16;

    logic [31:0]         instr;
    logic                in_valid;
    logic                in_ready;
    logic                flush;
    logic [DEPTH*CW-1:0] ctrl_o;
    logic [DEPTH-1:0]    valid_o;
    logic                hazard_o;
    logic                illegal_o;

    modport master (
        output instr, in_valid, flush,
        input  in_ready, ctrl_o, valid_o, hazard_o, illegal_o
    );

    modport slave (
        input  instr, in_valid, flush,
        output in_ready, ctrl_o, valid_o, hazard_o, illegal_o
    );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// Decodes a 32-bit instruction into a 16-bit control word and shifts it through
// DEPTH registered stages, stalling stage 0 on a load-use hazard or a flush.
module ctrl_decode_pipe #(
    parameter int DEPTH = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    ctrl_decode_pipe_if.slave bus
);
    localparam int CW      = 16;
    localparam int F_SHIFT = 0;
    localparam int F_ALU   = 1;
    localparam int F_MSIZE = 5;
    localparam int F_MEN   = 6;
    localparam int F_MRW   = 7;
    localparam int F_LOAD  = 8;
    localparam int F_S     = 9;
    localparam int F_RFE   = 10;
    localparam int F_B     = 11;
    localparam int F_RD    = 12;

    logic [DEPTH*CW-1:0] ctrl_q, ctrl_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic                illegal_q, illegal_d;
    logic [CW-1:0]       dec_word;
    logic                dec_illegal;
    logic                hazard;
    logic                take;
    logic [2:0]          cls;
    logic [3:0]          s0_rd;
    logic                unused_bits;

    assign cls         = bus.instr[27:25];
    assign s0_rd       = ctrl_q[F_RD +: 4];
    assign unused_bits = ^{bus.instr[31:28], bus.instr[6:4]};

    always_comb begin : decode
        dec_word    = '0;
        dec_illegal = 1'b0;
        if (bus.instr != 32'd0) begin
            case (cls)
                3'b000, 3'b001: begin
                    dec_word[F_S]        = bus.instr[20];
                    dec_word[F_ALU +: 4] = bus.instr[24:21];
                    dec_word[F_RFE]      = 1'b1;
                    dec_word[F_SHIFT]    = cls[0] | (bus.instr[11:7] != 5'd0);
                    dec_word[F_RD +: 4]  = bus.instr[15:12];
                end
                3'b010, 3'b011: begin
                    dec_word[F_SHIFT]    = ~cls[0];
                    dec_word[F_ALU +: 4] = bus.instr[23] ? 4'b0100 : 4'b0010;
                    dec_word[F_MSIZE]    = bus.instr[22];
                    dec_word[F_MEN]      = 1'b1;
                    dec_word[F_LOAD]     = bus.instr[20];
                    dec_word[F_RFE]      = bus.instr[20];
                    dec_word[F_MRW]      = ~bus.instr[20];
                    dec_word[F_RD +: 4]  = bus.instr[15:12];
                end
                3'b101: begin
                    dec_word[F_B]        = 1'b1;
                    dec_word[F_RFE]      = bus.instr[24];
                    dec_word[F_ALU +: 4] = bus.instr[24] ? 4'b0100 : 4'b0010;
                    dec_word[F_RD +: 4]  = bus.instr[24] ? 4'd14 : 4'd0;
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    // Rm is only a register source for DPSI and register-offset load/store.
    always_comb begin : hazard_detect
        hazard = 1'b0;
        if (!bus.flush && bus.in_valid && valid_q[0] && ctrl_q[F_LOAD]) begin
            hazard = (s0_rd == bus.instr[19:16]) ||
                     (((cls == 3'b000) || (cls == 3'b011)) && (s0_rd == bus.instr[3:0]));
        end
    end

    always_comb begin : next_state
        take         = bus.in_valid & ~hazard & ~bus.flush;
        ctrl_d       = ctrl_q << CW;
        ctrl_d[CW-1:0] = take ? dec_word : '0;
        valid_d      = valid_q << 1;
        valid_d[0]   = take;
        illegal_d    = take & dec_illegal;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q    <= '0;
            valid_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.ctrl_o    = ctrl_q;
    assign bus.valid_o   = valid_q;
    assign bus.illegal_o = illegal_q;
    assign bus.hazard_o  = hazard;
    assign bus.in_ready  = ~hazard;
endmodule

// File: doc/ctrl_decode_pipe.md
CTRL_DECODE_PIPE -- requirements
Module: ctrl_decode_pipe

Interface
REQ-001 Parameter DEPTH, default 3, sets the number of registered control stages (ID/EX, EX/MEM, MEM/WB); legal range 1..4.
REQ-002 Parameter CW, default 16, is the control word width; fixed at 16, not overridable.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 instr  in  32  instruction presented by the fetch stage.
REQ-006 in_valid  in  1  instr is valid this cycle.
REQ-007 in_ready  out  1  block accepts instr this cycle; equals ~hazard_o.
REQ-008 flush  in  1  discards the instruction being decoded and the stage-0 contents.
REQ-009 ctrl_o  out  DEPTH*CW  packed control words; stage k occupies bits [k*CW+CW-1 : k*CW].
REQ-010 valid_o  out  DEPTH  per-stage valid bits.
REQ-011 hazard_o  out  1  load-use stall active this cycle (combinational).
REQ-012 illegal_o  out  1  registered one-cycle pulse for an accepted unsupported encoding.

Function
REQ-013 Control word layout, LSB first: [0] shift_imm, [4:1] alu_op, [5] m_size, [6] m_enable, [7] m_rw, [8] load, [9] S, [10] rf_enable, [11] b_instr, [15:12] rd (= instr[15:12]).
REQ-014 Decode on instr[27:25] = 000 (DPSI): S=I[20], alu_op=I[24:21], rf_enable=1, shift_imm=(I[11:7]!=0), memory bits=0.
REQ-015 Decode on 001 (DPI): S=I[20], alu_op=I[24:21], rf_enable=1, shift_imm=1, memory bits=0.
REQ-016 Decode on 010/011 (LS imm/reg): S=0, shift_imm=1 for 010 and 0 for 011, alu_op=0100 if I[23] else 0010, m_size=I[22], m_enable=1, load=I[20], rf_enable=I[20], m_rw=~I[20].
REQ-017 Decode on 101 (B/BL): b_instr=1, rf_enable=I[24], alu_op=0100 if I[24] else 0010, rd=4'd14 if I[24]; all other bits 0.
REQ-018 Any other instr[27:25] value, and instr==0, decodes to the all-zero control word (NOP); the other encodings additionally set illegal_o.
REQ-019 Hazard: hazard_o=1 when valid_o[0], stage-0 load=1, in_valid=1, and stage-0 rd equals instr[19:16], or equals instr[3:0] for class 000/011.
REQ-020 Hazard stall: stage 0 loads a bubble (word 0, valid 0), stages 1..DEPTH-1 advance, and instr is not consumed; the hazard clears after one cycle.
REQ-021 Normal advance each cycle: stage 0 <= decoded word with valid = in_valid & in_ready; stage k <= stage k-1 for k>=1.
REQ-022 Flush: stage 0 <= bubble, illegal_o=0, hazard_o forced to 0; later stages advance normally. Flush overrides a simultaneous hazard.
REQ-023 Latency: an instruction accepted at edge n appears in stage k after edge n+k; throughput is one per cycle when there is no hazard.
REQ-024 Bubbles and invalid stages carry an all-zero control word so downstream enables stay inactive.

Reset
REQ-025 While reset_n=0: all ctrl_o=0, valid_o=0, illegal_o=0, independent of clk.
REQ-026 The first capture is on the first rising edge after reset_n deasserts; an instruction in flight when reset asserts is lost without a partial update.

Verification
REQ-027 0xE0821003 (ADD R1,R2,R3) accepted -> stage-0 word: alu_op=0100, rf_enable=1, shift_imm=0, rd=1, valid_o[0]=1; at DEPTH=3 it reaches stage 2 two cycles later.
REQ-028 0xE5921004 (LDR R1,[R2,#4]) followed by 0xE0814005 (ADD R4,R1,R5) -> hazard_o=1 for one cycle, in_ready=0, bubble in stage 0, ADD accepted on the next cycle.
REQ-029 Same pair as REQ-028 with flush=1 during the hazard cycle -> hazard_o=0, stage 0 is a bubble, the LDR still advances to stage 1.
REQ-030 0xEB000004 (BL) -> b_instr=1, rf_enable=1, alu_op=0100, rd=14; 0xEA000002 (B) -> rf_enable=0, alu_op=0010.
REQ-031 instr=0xE6000010 (class 011 reg) accepted -> shift_imm=0; instr=0xEE000000 (class 111) -> NOP word and a single-cycle illegal_o pulse.
REQ-032 reset_n pulsed low mid-stream between edges -> all outputs 0 immediately; sweep DEPTH=1 and DEPTH=4 with a 10-instruction stream to check shift-through and no X values.
